sys_arr_operand_feeder: RTL and testbench
=========================================

// Module: sys_arr_operand_feeder
// PURPOSE
// Source end of the systolic-array operand interface. Buffers A (MxN) and B (NxK) single_float
// matrices written over a load port, then on start streams them into the west (A rows) and
// north (B columns) array edges as skewed wavefronts with per-lane valids. Sits between the
// host/loader and sys_array; pulses done once the final wavefront has been issued.
// PARAMETERS
// M      2   rows of A / array rows (west lanes)
// N      3   inner dimension (A cols, B rows)
// K      2   cols of B / array cols (north lanes)
// DW     32  element width; IEEE-754 single_float, passed through unmodified
// AW     $clog2(max(M*N,N*K)) (min 1)  load address width
// PORTS
// CLK      in   1     clock, rising edge
// nRST     in   1     async active-low reset
// ld_en    in   1     load strobe
// ld_sel   in   1     0 = write A, 1 = write B
// ld_addr  in   AW    flat row-major index: A r*N+c, B r*K+c
// ld_data  in   DW    element value
// start    in   1     begin streaming (single-cycle pulse)
// err_clr  in   1     clears sticky error
// a_out    out  M*DW  west lane i at bits [i*DW +: DW]
// a_vld    out  M     per-row valid
// b_out    out  K*DW  north lane j at bits [j*DW +: DW]
// b_vld    out  K     per-col valid
// busy     out  1     high while streaming
// done     out  1     1-cycle pulse after last wavefront
// error    out  1     sticky protocol error
// BEHAVIOUR
// - Reset (async, nRST=0): state IDLE; both buffers, a_out, b_out, a_vld, b_vld, busy, done
//   and error forced to 0. Assertion mid-stream aborts immediately; no done is issued.
// - FSM: IDLE -(start)-> STREAM -(t==T-1)-> DONE -> IDLE; T = N + max(M,K) - 1.
// - IDLE: ld_en writes the selected buffer on posedge. ld_addr >= M*N (A) or >= N*K (B):
//   write dropped, error set.
// - start sampled in IDLE: cycle+1 outputs carry wavefront t=0 with busy=1. Each later cycle
//   advances t by 1, through t=T-1.
// - Wavefront t: a_out[i] = A[i][t-i], a_vld[i]=1 iff 0 <= t-i < N; b_out[j] = B[t-j][j],
//   b_vld[j]=1 iff 0 <= t-j < N. Invalid lanes drive data 0.
// - All outputs are registered; no combinational path from inputs to outputs.
// - DONE (cycle T+1 after start): done=1, busy=0, all valids 0 for one cycle; then IDLE.
//   Buffers are retained, so start may replay the same operands.
// - ld_en or start while busy=1 or done=1: ignored, error set. Streaming is unaffected.
// - start and ld_en in the same IDLE cycle: the write commits first and that element
//   is streamed.
// - err_clr clears error next cycle. If a new error event coincides, error stays 1
//   (set wins).
// - No backpressure: the array consumes one wavefront per cycle unconditionally.
// TESTING (M=2,N=3,K=2; A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]])
// 1 load A,B, start -> c1 a=(1,-) b=(7,-); c2 a=(2,4) b=(9,8); c3 a=(3,5) b=(11,10);
//   c4 a=(-,6) b=(-,12); c5 done=1, busy=0; '-' means vld=0 and data 0.
// 2 second start after done, no reload -> identical 4-cycle stream, done at c5.
// 3 start at c2 of stream; ld_en at c3 -> error=1 from next edge, stream still matches scenario 1.
// 4 ld_sel=0, ld_addr=6 -> error=1, A unchanged; err_clr -> error=0 next cycle.
// 5 nRST low at c2 of stream -> all outputs 0 immediately, no done; post-reset start -> all lanes 0.
// 6 same-cycle ld_en (A[0][0]=2.5) and start -> c1 a_out[0]=2.5 (0x40200000).

Source files
------------

// File: rtl/sys_arr_operand_feeder.sv
// rtl/sys_arr_operand_feeder.sv - operand buffer and skewed wavefront feeder for the systolic array
module sys_arr_operand_feeder #(
    parameter int M  = 2,
    parameter int N  = 3,
    parameter int K  = 2,
    parameter int DW = 32,
    parameter int AW = (((M * N > N * K) ? M * N : N * K) > 1) ?
                       $clog2((M * N > N * K) ? M * N : N * K) : 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ld_en,
    input  logic            ld_sel,
    input  logic [AW-1:0]   ld_addr,
    input  logic [DW-1:0]   ld_data,
    input  logic            start,
    input  logic            err_clr,
    output logic [M*DW-1:0] a_out,
    output logic [M-1:0]    a_vld,
    output logic [K*DW-1:0] b_out,
    output logic [K-1:0]    b_vld,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam int MX  = (M > K) ? M : K;
    localparam int T   = N + MX - 1;
    localparam int TW  = (T > 1) ? $clog2(T) : 1;
    localparam int AIW = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int BIW = (N * K > 1) ? $clog2(N * K) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [DW-1:0]   a_mem_q [M*N];
    logic [DW-1:0]   a_mem_d [M*N];
    logic [DW-1:0]   b_mem_q [N*K];
    logic [DW-1:0]   b_mem_d [N*K];
    logic [M*DW-1:0] a_out_q, a_out_d;
    logic [M-1:0]    a_vld_q, a_vld_d;
    logic [K*DW-1:0] b_out_q, b_out_d;
    logic [K-1:0]    b_vld_q, b_vld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            err_ev;
    logic            emit;

    // Next state, buffer writes, next wavefront and sticky error.
    // The wavefront is built from the post-write buffers so a load that
    // coincides with start is already visible in wavefront 0.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_mem_d = a_mem_q;
        b_mem_d = b_mem_q;
        a_out_d = '0;
        a_vld_d = '0;
        b_out_d = '0;
        b_vld_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        err_ev  = 1'b0;
        emit    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ld_en) begin
                    if (!ld_sel) begin
                        if (int'(ld_addr) < M * N) a_mem_d[AIW'(ld_addr)] = ld_data;
                        else                       err_ev = 1'b1;
                    end else begin
                        if (int'(ld_addr) < N * K) b_mem_d[BIW'(ld_addr)] = ld_data;
                        else                       err_ev = 1'b1;
                    end
                end
                if (start) begin
                    state_d = S_STREAM;
                    t_d     = '0;
                    emit    = 1'b1;
                end
            end
            S_STREAM: begin
                if (ld_en || start) err_ev = 1'b1;
                if (t_q == TW'(T - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    t_d  = t_q + 1'b1;
                    emit = 1'b1;
                end
            end
            S_DONE: begin
                if (ld_en || start) err_ev = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            busy_d = 1'b1;
            // Row i of A enters lane i delayed by i cycles; column j of B likewise.
            for (int i = 0; i < M; i++) begin
                if (int'(t_d) >= i && int'(t_d) - i < N) begin
                    a_vld_d[i]           = 1'b1;
                    a_out_d[i*DW +: DW]  = a_mem_d[AIW'(i * N + int'(t_d) - i)];
                end
            end
            for (int j = 0; j < K; j++) begin
                if (int'(t_d) >= j && int'(t_d) - j < N) begin
                    b_vld_d[j]           = 1'b1;
                    b_out_d[j*DW +: DW]  = b_mem_d[BIW'((int'(t_d) - j) * K + j)];
                end
            end
        end

        if (err_clr) err_d = 1'b0;
        if (err_ev)  err_d = 1'b1;
    end

    // State, buffers and registered outputs; reset clears everything including the buffers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            for (int i = 0; i < M * N; i++) a_mem_q[i] <= '0;
            for (int i = 0; i < N * K; i++) b_mem_q[i] <= '0;
            a_out_q <= '0;
            a_vld_q <= '0;
            b_out_q <= '0;
            b_vld_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            for (int i = 0; i < M * N; i++) a_mem_q[i] <= a_mem_d[i];
            for (int i = 0; i < N * K; i++) b_mem_q[i] <= b_mem_d[i];
            a_out_q <= a_out_d;
            a_vld_q <= a_vld_d;
            b_out_q <= b_out_d;
            b_vld_q <= b_vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign a_out = a_out_q;
    assign a_vld = a_vld_q;
    assign b_out = b_out_q;
    assign b_vld = b_vld_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = err_q;

endmodule

// File: tb/tb_sys_arr_operand_feeder.sv
// tb/tb_sys_arr_operand_feeder.sv - scoreboard bench for sys_arr_operand_feeder
module tb_sys_arr_operand_feeder;

    localparam int M  = 2;
    localparam int N  = 3;
    localparam int K  = 2;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int T  = 4;

    logic            CLK;
    logic            nRST;
    logic            ld_en;
    logic            ld_sel;
    logic [AW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic            start;
    logic            err_clr;
    logic [M*DW-1:0] a_out;
    logic [M-1:0]    a_vld;
    logic [K*DW-1:0] b_out;
    logic [K-1:0]    b_vld;
    logic            busy;
    logic            done;
    logic            error;

    sys_arr_operand_feeder #(.M(M), .N(N), .K(K), .DW(DW)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .ld_en   (ld_en),
        .ld_sel  (ld_sel),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .start   (start),
        .err_clr (err_clr),
        .a_out   (a_out),
        .a_vld   (a_vld),
        .b_out   (b_out),
        .b_vld   (b_vld),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [M*DW-1:0] a;
        logic [M-1:0]    av;
        logic [K*DW-1:0] b;
        logic [K-1:0]    bv;
        logic            bsy;
        logic            dn;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ma [M*N];
    logic [31:0] mb [N*K];
    int          m_left;
    logic        m_err;
    int          n_checks;
    int          n_fail;

    logic [31:0] a_init [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] b_init [6] = '{32'h40E00000, 32'h41000000, 32'h41100000,
                                32'h41200000, 32'h41300000, 32'h41400000};

    // Hand-derived stream for scenario 1 (lane 1 in upper word, lane 0 in lower).
    logic [63:0] c_a   [5] = '{64'h00000000_3F800000, 64'h40800000_40000000,
                               64'h40A00000_40400000, 64'h40C00000_00000000, 64'h0};
    logic [63:0] c_b   [5] = '{64'h00000000_40E00000, 64'h41000000_41100000,
                               64'h41200000_41300000, 64'h41400000_00000000, 64'h0};
    logic [1:0]  c_vld [5] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
    logic [1:0]  c_bd  [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_stream();
        exp_t e;
        for (int t = 0; t < T; t++) begin
            e.a = '0; e.av = '0; e.b = '0; e.bv = '0; e.bsy = 1'b1; e.dn = 1'b0;
            for (int i = 0; i < M; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    e.av[i]          = 1'b1;
                    e.a[i*DW +: DW]  = ma[i * N + (t - i)];
                end
            end
            for (int j = 0; j < K; j++) begin
                if (t - j >= 0 && t - j < N) begin
                    e.bv[j]          = 1'b1;
                    e.b[j*DW +: DW]  = mb[(t - j) * K + j];
                end
            end
            sb.push_back(e);
        end
        e.a = '0; e.av = '0; e.b = '0; e.bv = '0; e.bsy = 1'b0; e.dn = 1'b1;
        sb.push_back(e);
    endtask

    task automatic step(input logic le, input logic sel, input int addr,
                        input logic [31:0] data, input logic st, input logic ec);
        logic ev;
        ev      = 1'b0;
        ld_en   = le;
        ld_sel  = sel;
        ld_addr = addr[AW-1:0];
        ld_data = data;
        start   = st;
        err_clr = ec;
        if (m_left == 0) begin
            if (le) begin
                if (!sel && addr < M * N)     ma[addr] = data;
                else if (sel && addr < N * K) mb[addr] = data;
                else                          ev = 1'b1;
            end
            if (st) begin
                push_stream();
                m_left = T + 1;
            end
        end else begin
            if (le || st) ev = 1'b1;
            m_left--;
        end
        if (ec) m_err = 1'b0;
        if (ev) m_err = 1'b1;
        @(posedge CLK);
        #1;
        ld_en   = 1'b0;
        start   = 1'b0;
        err_clr = 1'b0;
        check("error", {63'd0, error}, {63'd0, m_err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_const(input int c);
        check("s1_a_out", a_out, c_a[c]);
        check("s1_a_vld", {62'd0, a_vld}, {62'd0, c_vld[c]});
        check("s1_b_out", b_out, c_b[c]);
        check("s1_b_vld", {62'd0, b_vld}, {62'd0, c_vld[c]});
        check("s1_busy_done", {62'd0, busy, done}, {62'd0, c_bd[c]});
    endtask

    // Scoreboard: every cycle the DUT presents a wavefront or done, pop and compare.
    always @(negedge CLK) begin
        if (nRST && (busy || done)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_a_out", a_out, e.a);
                check("sb_a_vld", {62'd0, a_vld}, {62'd0, e.av});
                check("sb_b_out", b_out, e.b);
                check("sb_b_vld", {62'd0, b_vld}, {62'd0, e.bv});
                check("sb_busy", {63'd0, busy}, {63'd0, e.bsy});
                check("sb_done", {63'd0, done}, {63'd0, e.dn});
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_left   = 0;
        m_err    = 1'b0;
        for (int i = 0; i < 6; i++) begin ma[i] = '0; mb[i] = '0; end
        nRST    = 1'b0;
        ld_en   = 1'b0;
        ld_sel  = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        start   = 1'b0;
        err_clr = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_a_out", a_out, 64'h0);
        check("rst_b_out", b_out, 64'h0);
        check("rst_flags", {58'd0, a_vld, b_vld, busy, done, error}, 64'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Scenario 1: load A and B, stream, compare against hand-derived values.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, i, a_init[i], 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, i, b_init[i], 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        check_const(0);
        for (int c = 1; c < 5; c++) begin
            idle(1);
            check_const(c);
        end
        idle(1);
        check("idle_after_done", {62'd0, busy, done}, 64'h0);

        // Scenario 2: replay without reload.
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        check_const(0);
        for (int c = 1; c < 5; c++) begin
            idle(1);
            check_const(c);
        end
        idle(2);

        // Scenario 3: start at c2 and a load at c3 are ignored but flag error.
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1);

        // Scenario 4: out-of-range A write, then clear; set wins over clear.
        step(1'b1, 1'b0, 6, 32'hBAADF00D, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 7, 32'hBAADF00D, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        check_const(0);
        idle(6);

        // Scenario 6: load and start in the same cycle; new value is streamed.
        step(1'b1, 1'b0, 0, 32'h40200000, 1'b1, 1'b0);
        check("same_cycle_a0", {32'd0, a_out[31:0]}, 64'h40200000);
        idle(6);

        // Scenario 5: reset mid-stream clears everything at once; no done follows.
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        idle(1);
        nRST = 1'b0;
        #1;
        check("abort_a_out", a_out, 64'h0);
        check("abort_b_out", b_out, 64'h0);
        check("abort_flags", {58'd0, a_vld, b_vld, busy, done, error}, 64'h0);
        sb.delete();
        m_left = 0;
        m_err  = 1'b0;
        for (int i = 0; i < 6; i++) begin ma[i] = '0; mb[i] = '0; end
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("no_done_after_abort", {62'd0, busy, done}, 64'h0);
            idle(1);
        end
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        check("post_rst_vld", {60'd0, a_vld, b_vld}, {60'd0, 2'b01, 2'b01});
        check("post_rst_data", a_out | b_out, 64'h0);
        idle(6);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
